// File: rtl/tt_seq_pkg.sv
// rtl/tt_seq_pkg.sv - shared types and constants for truth_table_sequencer
package tt_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } tt_state_e;

    localparam int SETTLE_CNT_W = 4;

endpackage

// File: rtl/truth_table_sequencer.sv
// rtl/truth_table_sequencer.sv - exhaustive stimulus walker and truth-table checker
module truth_table_sequencer
    import tt_seq_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [(2**N_IN)-1:0]  expected,
    output logic [N_IN-1:0]       dut_in,
    input  logic                  dut_out,
    output logic                  busy,
    output logic                  done,
    output logic [(2**N_IN)-1:0]  table_out,
    output logic                  pass,
    output logic [N_IN:0]         mismatch_cnt,
    output logic [N_IN-1:0]       first_fail,
    output logic                  fail_valid
);

    localparam int N_VEC = 2**N_IN;
    localparam logic [SETTLE_CNT_W-1:0] SETTLE_LAST = SETTLE_CNT_W'(SETTLE - 1);
    localparam logic [N_IN-1:0]         IDX_LAST    = N_IN'(N_VEC - 1);

    tt_state_e               state, state_next;
    logic [N_IN-1:0]         idx;
    logic [SETTLE_CNT_W-1:0] settle_cnt;
    logic [N_VEC-1:0]        exp_q;
    logic                    sample_miss;
    logic                    last_vec;

    assign sample_miss = (dut_out != exp_q[idx]);
    assign last_vec    = (idx == IDX_LAST);

    // The applied vector is the index itself, so it stays on the last vector after DONE.
    assign dut_in = idx;
    assign busy   = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done   = (state == ST_DONE);

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:   if (start) state_next = ST_SETTLE;
            ST_SETTLE: begin
                if (abort)                           state_next = ST_IDLE;
                else if (settle_cnt == SETTLE_LAST)  state_next = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (abort)         state_next = ST_IDLE;
                else if (last_vec) state_next = ST_DONE;
                else               state_next = ST_SETTLE;
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_IDLE;
            idx          <= '0;
            settle_cnt   <= '0;
            exp_q        <= '0;
            table_out    <= '0;
            pass         <= 1'b0;
            mismatch_cnt <= '0;
            first_fail   <= '0;
            fail_valid   <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        exp_q        <= expected;
                        table_out    <= '0;
                        pass         <= 1'b0;
                        mismatch_cnt <= '0;
                        first_fail   <= '0;
                        fail_valid   <= 1'b0;
                        idx          <= '0;
                        settle_cnt   <= '0;
                    end
                end
                ST_SETTLE: begin
                    if (abort) begin
                        idx  <= '0;
                        pass <= 1'b0;
                    end else begin
                        settle_cnt <= settle_cnt + SETTLE_CNT_W'(1);
                    end
                end
                ST_SAMPLE: begin
                    if (abort) begin
                        idx  <= '0;
                        pass <= 1'b0;
                    end else begin
                        table_out[idx] <= dut_out;
                        if (sample_miss) begin
                            mismatch_cnt <= mismatch_cnt + (N_IN+1)'(1);
                            if (!fail_valid) begin
                                first_fail <= idx;
                                fail_valid <= 1'b1;
                            end
                        end
                        // Table matches iff no earlier miss and this final sample agrees.
                        if (last_vec) begin
                            pass <= !fail_valid && !sample_miss;
                        end else begin
                            idx        <= idx + N_IN'(1);
                            settle_cnt <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
